// File: rtl/ext_pwr_sequencer_pkg.sv
// Purpose: shared types for the external-domain power sequencer (state enum, control decode).
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package ext_pwr_seq_pkg;

  typedef enum logic [3:0] {
    ON     = 4'd0,
    PD_CG  = 4'd1,
    PD_ISO = 4'd2,
    PD_RST = 4'd3,
    PD_SW  = 4'd4,
    OFF    = 4'd5,
    PU_SW  = 4'd6,
    PU_CG  = 4'd7,
    PU_RST = 4'd8,
    PU_ISO = 4'd9
  } pwr_state_e;

  // All domain controls are active-low; powered/busy are status flags.
  typedef struct packed {
    logic switch_n;
    logic iso_n;
    logic rst_n;
    logic clkgate_en_n;
    logic powered;
    logic busy;
  } pwr_ctrl_t;

  localparam pwr_ctrl_t CTRL_ON     = '{switch_n: 1'b0, iso_n: 1'b1, rst_n: 1'b1, clkgate_en_n: 1'b1, powered: 1'b1, busy: 1'b0};
  // Same as ON but with the domain reset held, so the domain leaves reset one edge after rst_i drops.
  localparam pwr_ctrl_t CTRL_RESET  = '{switch_n: 1'b0, iso_n: 1'b1, rst_n: 1'b0, clkgate_en_n: 1'b1, powered: 1'b1, busy: 1'b0};
  localparam pwr_ctrl_t CTRL_PD_CG  = '{switch_n: 1'b0, iso_n: 1'b1, rst_n: 1'b1, clkgate_en_n: 1'b0, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_PD_ISO = '{switch_n: 1'b0, iso_n: 1'b0, rst_n: 1'b1, clkgate_en_n: 1'b0, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_PD_RST = '{switch_n: 1'b0, iso_n: 1'b0, rst_n: 1'b0, clkgate_en_n: 1'b0, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_PD_SW  = '{switch_n: 1'b1, iso_n: 1'b0, rst_n: 1'b0, clkgate_en_n: 1'b0, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_OFF    = '{switch_n: 1'b1, iso_n: 1'b0, rst_n: 1'b0, clkgate_en_n: 1'b0, powered: 1'b0, busy: 1'b0};
  localparam pwr_ctrl_t CTRL_PU_SW  = '{switch_n: 1'b0, iso_n: 1'b0, rst_n: 1'b0, clkgate_en_n: 1'b0, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_PU_CG  = '{switch_n: 1'b0, iso_n: 1'b0, rst_n: 1'b0, clkgate_en_n: 1'b1, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_PU_RST = '{switch_n: 1'b0, iso_n: 1'b0, rst_n: 1'b1, clkgate_en_n: 1'b1, powered: 1'b0, busy: 1'b1};
  localparam pwr_ctrl_t CTRL_PU_ISO = '{switch_n: 1'b0, iso_n: 1'b1, rst_n: 1'b1, clkgate_en_n: 1'b1, powered: 1'b0, busy: 1'b1};

  function automatic pwr_ctrl_t ctrl_decode(pwr_state_e s);
    case (s)
      ON:      return CTRL_ON;
      PD_CG:   return CTRL_PD_CG;
      PD_ISO:  return CTRL_PD_ISO;
      PD_RST:  return CTRL_PD_RST;
      PD_SW:   return CTRL_PD_SW;
      OFF:     return CTRL_OFF;
      PU_SW:   return CTRL_PU_SW;
      PU_CG:   return CTRL_PU_CG;
      PU_RST:  return CTRL_PU_RST;
      PU_ISO:  return CTRL_PU_ISO;
      default: return CTRL_RESET;
    endcase
  endfunction

endpackage

// File: rtl/ext_pwr_sequencer_if.sv
// Purpose: control/status bundle between power-manager registers, sequencer and switch cell.
// Latency: n/a (wires only). Backpressure: none; requests are levels, ack is a level.
// Signals: pwr_off_req_i/pwr_on_req_i/err_clr_i/switch_ack_ni in; domain controls, status, state_o out.
interface ext_pwr_sequencer_if;
  logic       pwr_off_req_i;
  logic       pwr_on_req_i;
  logic       err_clr_i;
  logic       switch_ack_ni;
  logic       switch_no;
  logic       iso_no;
  logic       rst_no;
  logic       clkgate_en_no;
  logic       powered_o;
  logic       busy_o;
  logic       error_o;
  logic [3:0] state_o;

  // master: the requester / switch-cell side.
  modport master (
    output pwr_off_req_i, pwr_on_req_i, err_clr_i, switch_ack_ni,
    input  switch_no, iso_no, rst_no, clkgate_en_no, powered_o, busy_o, error_o, state_o
  );

  // slave: the sequencer.
  modport slave (
    input  pwr_off_req_i, pwr_on_req_i, err_clr_i, switch_ack_ni,
    output switch_no, iso_no, rst_no, clkgate_en_no, powered_o, busy_o, error_o, state_o
  );
endinterface

// File: rtl/ext_pwr_sequencer_timer.sv
// Purpose: shared step/timeout counter; load clears to 0, then counts up and saturates.
// Latency: done_o/timeout_o are combinational from the count register.
// Backpressure: none. Ports: clk_i, rst_i, load_i in; done_o, timeout_o out.
module ext_pwr_seq_timer #(
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic done_o,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(ACK_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Saturation keeps a long-overdue ack from wrapping back onto the timeout value.
  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Count is 0 in the first cycle of a state, so GAP_CYCLES-1 marks its last cycle.
  assign done_o    = (cnt == GAP_LAST);
  assign timeout_o = (ACK_TIMEOUT != 0) && (cnt == TMO_CNT);

endmodule

// File: rtl/ext_pwr_sequencer.sv
// Purpose: orders clock-gate, isolation, reset and switch controls for the external domain.
// Latency: controls change on the edge that samples the request/ack (Moore, decoded from next state).
// Backpressure: requests outside ON/OFF are dropped; switch ack is waited for indefinitely.
// Ports: clk_i, rst_i (sync, active high) plus bus (slave modport of ext_pwr_sequencer_if).
module ext_pwr_sequencer
  import ext_pwr_seq_pkg::*;
#(
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ext_pwr_sequencer_if.slave   bus
);

  pwr_state_e state_q;
  pwr_state_e state_d;
  pwr_ctrl_t  ctrl_q;
  logic       error_q;
  logic       gap_done;
  logic       ack_tmo;
  logic       tmr_load;
  logic       tmo_hit;

  ext_pwr_seq_timer #(
    .GAP_CYCLES  (GAP_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .done_o    (gap_done),
    .timeout_o (ack_tmo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ON:      if (bus.pwr_off_req_i) state_d = PD_CG;
      PD_CG:   if (gap_done) state_d = PD_ISO;
      PD_ISO:  if (gap_done) state_d = PD_RST;
      PD_RST:  if (gap_done) state_d = PD_SW;
      PD_SW:   if (bus.switch_ack_ni) state_d = OFF;
      OFF:     if (bus.pwr_on_req_i) state_d = PU_SW;
      PU_SW:   if (!bus.switch_ack_ni) state_d = PU_CG;
      PU_CG:   if (gap_done) state_d = PU_RST;
      PU_RST:  if (gap_done) state_d = PU_ISO;
      PU_ISO:  if (gap_done) state_d = ON;
      default: state_d = ON;
    endcase
  end

  // Counter restarts from 0 on every state entry.
  assign tmr_load = (state_d != state_q);

  // A timeout only counts while still waiting, i.e. the ack did not arrive on this same edge.
  assign tmo_hit = ack_tmo && (state_q == PD_SW || state_q == PU_SW) && !tmr_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ON;
      ctrl_q  <= CTRL_RESET;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
      if (tmo_hit) begin
        error_q <= 1'b1;
      end else if (bus.err_clr_i) begin
        error_q <= 1'b0;
      end
    end
  end

  assign bus.switch_no     = ctrl_q.switch_n;
  assign bus.iso_no        = ctrl_q.iso_n;
  assign bus.rst_no        = ctrl_q.rst_n;
  assign bus.clkgate_en_no = ctrl_q.clkgate_en_n;
  assign bus.powered_o     = ctrl_q.powered;
  assign bus.busy_o        = ctrl_q.busy;
  assign bus.error_o       = error_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_ext_pwr_sequencer.sv
// Purpose: self-checking bench for ext_pwr_sequencer with a delayed-ack switch-cell model.
// Latency: expectations are queued with their absolute edge number and compared on the falling edge.
// Backpressure: n/a.
module tb_ext_pwr_sequencer;
  import ext_pwr_seq_pkg::*;

  localparam int G   = 2;
  localparam int T   = 64;
  localparam int LAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic        ack_auto = 1'b1;
  logic        ack_manual = 1'b0;
  logic [31:0] sw_hist = '0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  ext_pwr_sequencer_if bus ();

  ext_pwr_sequencer #(
    .GAP_CYCLES  (G),
    .ACK_TIMEOUT (T),
    .CNT_W       (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Switch cell: ack follows switch_no LAT cycles later unless overridden.
  always @(negedge clk) begin
    sw_hist = {sw_hist[30:0], bus.switch_no};
    bus.switch_ack_ni = ack_auto ? sw_hist[LAT] : ack_manual;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // 0 switch_no, 1 iso_no, 2 rst_no, 3 clkgate_en_no, 4 powered_o, 5 busy_o, 6 error_o, 7 state_o
  function automatic logic [3:0] obs(int s);
    case (s)
      0: return {3'b000, bus.switch_no};
      1: return {3'b000, bus.iso_no};
      2: return {3'b000, bus.rst_no};
      3: return {3'b000, bus.clkgate_en_no};
      4: return {3'b000, bus.powered_o};
      5: return {3'b000, bus.busy_o};
      6: return {3'b000, bus.error_o};
      7: return bus.state_o;
      default: return 4'hx;
    endcase
  endfunction

  function automatic string sname(int s);
    case (s)
      0: return "switch_no";
      1: return "iso_no";
      2: return "rst_no";
      3: return "clkgate_en_no";
      4: return "powered_o";
      5: return "busy_o";
      6: return "error_o";
      default: return "state_o";
    endcase
  endfunction

  // Keep the scoreboard ordered by edge number.
  function automatic void push(int c, int s, logic [3:0] v);
    int i;
    exp_t item;
    item = '{c, s, v};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, item);
  endfunction

  task automatic test_reset();
    logic [3:0] want [8];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    want = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'(ON)};
    for (int s = 0; s < 8; s++) begin
      n_tests++;
      if (obs(s) !== want[s]) begin
        n_fail++;
        $display("FAIL reset_%s: got %0h expected %0h", sname(s), obs(s), want[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    want[2] = 4'd1;
    for (int s = 0; s < 8; s++) begin
      n_tests++;
      if (obs(s) !== want[s]) begin
        n_fail++;
        $display("FAIL release_%s: got %0h expected %0h", sname(s), obs(s), want[s]);
      end
    end
  endtask

  task automatic test_ignored_on();
    exp_t e;
    int   n;
    @(negedge clk);
    n = cyc;
    bus.pwr_on_req_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      push(n + k, 7, ON);
      push(n + k, 5, 4'd0);
    end
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (obs(e.sig) !== e.val) begin
          n_fail++;
          $display("FAIL ign_on_%s @%0d: got %0h expected %0h", sname(e.sig), cyc, obs(e.sig), e.val);
        end
      end
      if (sb.size() > 0) @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL ign_on_bound: %0d expectations not reached", sb.size());
      sb.delete();
    end
    bus.pwr_on_req_i = 1'b0;
  endtask

  // Off request held high throughout: it must not disturb PD_ISO nor restart anything in OFF.
  task automatic test_power_down();
    exp_t e;
    int   n, m;
    @(negedge clk);
    n = cyc;
    bus.pwr_off_req_i = 1'b1;
    m = n + 1 + 3 * G + LAT;
    push(n + 1, 3, 4'd0);          push(n + 1, 7, PD_CG);  push(n + 1, 5, 4'd1); push(n + 1, 1, 4'd1);
    push(n + G, 1, 4'd1);          push(n + G, 7, PD_CG);
    push(n + 1 + G, 1, 4'd0);      push(n + 1 + G, 7, PD_ISO); push(n + 1 + G, 2, 4'd1);
    push(n + 2 * G, 2, 4'd1);      push(n + 2 * G, 7, PD_ISO);
    push(n + 1 + 2 * G, 2, 4'd0);  push(n + 1 + 2 * G, 7, PD_RST); push(n + 1 + 2 * G, 0, 4'd0);
    push(n + 3 * G, 0, 4'd0);
    push(n + 1 + 3 * G, 0, 4'd1);  push(n + 1 + 3 * G, 7, PD_SW);
    push(m, 7, PD_SW);
    push(m + 1, 7, OFF); push(m + 1, 5, 4'd0); push(m + 1, 4, 4'd0); push(m + 1, 6, 4'd0); push(m + 1, 0, 4'd1);
    push(m + 4, 7, OFF);
    for (int k = 0; k < 80 && sb.size() > 0; k++) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (obs(e.sig) !== e.val) begin
          n_fail++;
          $display("FAIL pd_%s @%0d: got %0h expected %0h", sname(e.sig), cyc, obs(e.sig), e.val);
        end
      end
      if (sb.size() > 0) @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL pd_bound: %0d expectations not reached", sb.size());
      sb.delete();
    end
    bus.pwr_off_req_i = 1'b0;
  endtask

  // Both requests high in OFF: only the on request acts.
  task automatic test_power_up();
    exp_t e;
    int   n, m;
    @(negedge clk);
    n = cyc;
    bus.pwr_on_req_i  = 1'b1;
    bus.pwr_off_req_i = 1'b1;
    m = n + 1 + LAT;
    push(n + 1, 0, 4'd0); push(n + 1, 7, PU_SW); push(n + 1, 5, 4'd1); push(n + 1, 4, 4'd0); push(n + 1, 3, 4'd0);
    push(m, 3, 4'd0);     push(m, 7, PU_SW);
    push(m + 1, 3, 4'd1); push(m + 1, 7, PU_CG);
    push(m + G, 2, 4'd0);
    push(m + 1 + G, 2, 4'd1);     push(m + 1 + G, 7, PU_RST);
    push(m + 2 * G, 1, 4'd0);
    push(m + 1 + 2 * G, 1, 4'd1); push(m + 1 + 2 * G, 7, PU_ISO);
    push(m + 3 * G, 4, 4'd0);     push(m + 3 * G, 5, 4'd1);
    push(m + 1 + 3 * G, 7, ON);   push(m + 1 + 3 * G, 4, 4'd1); push(m + 1 + 3 * G, 5, 4'd0);
    @(negedge clk);
    bus.pwr_on_req_i  = 1'b0;
    bus.pwr_off_req_i = 1'b0;
    for (int k = 0; k < 80 && sb.size() > 0; k++) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (obs(e.sig) !== e.val) begin
          n_fail++;
          $display("FAIL pu_%s @%0d: got %0h expected %0h", sname(e.sig), cyc, obs(e.sig), e.val);
        end
      end
      if (sb.size() > 0) @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL pu_bound: %0d expectations not reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int         n;
    logic [3:0] want [8];
    @(posedge clk);
    #1;
    ack_auto   = 1'b0;
    ack_manual = 1'b0;
    @(negedge clk);
    n = cyc;
    bus.pwr_off_req_i = 1'b1;
    @(negedge clk);
    bus.pwr_off_req_i = 1'b0;
    while (cyc < n + 1 + 3 * G + 3) @(negedge clk);
    n_tests++;
    if (bus.state_o !== 4'(PD_SW)) begin
      n_fail++;
      $display("FAIL mid_pre_state: got %0h expected %0h", bus.state_o, 4'(PD_SW));
    end
    rst = 1'b1;
    @(negedge clk);
    want = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'(ON)};
    for (int s = 0; s < 8; s++) begin
      n_tests++;
      if (obs(s) !== want[s]) begin
        n_fail++;
        $display("FAIL mid_rst_%s: got %0h expected %0h", sname(s), obs(s), want[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.rst_no !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release_rst_no: got %0b expected 1", bus.rst_no);
    end
    @(posedge clk);
    #1;
    ack_auto = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n, ent;
    logic reached;
    @(posedge clk);
    #1;
    ack_auto   = 1'b0;
    ack_manual = 1'b0;
    @(negedge clk);
    n = cyc;
    bus.pwr_off_req_i = 1'b1;
    ent = n + 1 + 3 * G;
    push(ent, 7, PD_SW);   push(ent, 6, 4'd0);
    push(ent + T, 6, 4'd0);
    push(ent + T + 1, 6, 4'd1); push(ent + T + 1, 7, PD_SW);
    push(ent + T + 10, 6, 4'd1); push(ent + T + 10, 7, PD_SW);
    @(negedge clk);
    bus.pwr_off_req_i = 1'b0;
    for (int k = 0; k < 120 && sb.size() > 0; k++) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (obs(e.sig) !== e.val) begin
          n_fail++;
          $display("FAIL tmo_%s @%0d: got %0h expected %0h", sname(e.sig), cyc, obs(e.sig), e.val);
        end
      end
      if (sb.size() > 0) @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL tmo_bound: %0d expectations not reached", sb.size());
      sb.delete();
    end
    // Late ack still completes the power-down.
    @(posedge clk);
    #1;
    ack_manual = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 6 && !reached; k++) begin
      @(negedge clk);
      reached = (bus.state_o === 4'(OFF));
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL tmo_late_ack_state: got %0h expected %0h", bus.state_o, 4'(OFF));
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: got %0b expected 1", bus.error_o);
    end
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    n_tests++;
    if (bus.error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: got %0b expected 0", bus.error_o);
    end
    @(posedge clk);
    #1;
    ack_auto = 1'b1;
  endtask

  initial begin
    bus.pwr_off_req_i = 1'b0;
    bus.pwr_on_req_i  = 1'b0;
    bus.err_clr_i     = 1'b0;
    test_reset();
    test_ignored_on();
    test_power_down();
    test_power_up();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_pwr_sequencer.md
# ext_pwr_sequencer

Power-domain sequencer for the external subsystem (NTT/INTT accelerator domain) of the MCU. It converts software power-off and power-on requests into an ordered sequence of clock-gate, isolation, reset and power-switch controls, and waits for the power-switch cell acknowledge between steps. It sits between the power-manager control registers and the external domain's `external_subsystem_*` controls. It also flags acknowledges that do not arrive in time.

## Interface
- `GAP_CYCLES`, 2: number of cycles each non-switch step is held before the next step (≥1).
- `ACK_TIMEOUT`, 64: number of cycles to wait for the switch acknowledge before `error_o` is raised; 0 disables the check.
- `CNT_W`, 8: width of the shared step/timeout counter; must hold max(`GAP_CYCLES`, `ACK_TIMEOUT`).

Ports (direction, width, meaning):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `pwr_off_req_i` in 1: level request to power the domain down; sampled only in `ON`.
- `pwr_on_req_i` in 1: level request to power the domain up; sampled only in `OFF`.
- `err_clr_i` in 1: clears the sticky `error_o`.
- `switch_ack_ni` in 1: acknowledge from the switch cell (0 = domain powered).
- `switch_no` out 1: switch control (0 = power on).
- `iso_no` out 1: isolation control (0 = isolated).
- `rst_no` out 1: domain reset (0 = reset asserted).
- `clkgate_en_no` out 1: clock-gate control (0 = clock gated).
- `powered_o` out 1: 1 only in `ON`.
- `busy_o` out 1: 1 in every transitional state.
- `error_o` out 1: sticky acknowledge-timeout flag.
- `state_o` out 4: current FSM state, for debug.

## Operation
- All outputs are registered Moore outputs, decoded from the next state.
- Reset: the state is `ON` with `switch_no`=0, `iso_no`=1, `clkgate_en_no`=1, `rst_no`=0, `powered_o`=1, `busy_o`=0, `error_o`=0.
  - `rst_no` goes to 1 on the first edge after `rst_i` falls.
- Power-down path: `ON` → `PD_CG` (`clkgate_en_no`=0) → `PD_ISO` (`iso_no`=0) → `PD_RST` (`rst_no`=0) → `PD_SW` (`switch_no`=1, wait until `switch_ack_ni`=1) → `OFF`.
- Power-up path: `OFF` → `PU_SW` (`switch_no`=0, wait until `switch_ack_ni`=0) → `PU_CG` (`clkgate_en_no`=1) → `PU_RST` (`rst_no`=1) → `PU_ISO` (`iso_no`=1) → `ON`.
- Each control keeps its new value for the rest of the sequence.
- `PD_CG`, `PD_ISO`, `PD_RST`, `PU_CG`, `PU_RST` and `PU_ISO` each last exactly `GAP_CYCLES` cycles, counted by the shared counter, which reloads on every state entry.
- In `PD_SW` and `PU_SW` the counter counts up from 0.
  - When it reaches `ACK_TIMEOUT` without the expected acknowledge, `error_o` is set.
  - The FSM keeps waiting and never aborts.
  - A late acknowledge still completes the sequence.
- Request handling:
  - Requests arriving during busy states are ignored, not queued.
  - `pwr_on_req_i` is ignored in `ON`; `pwr_off_req_i` is ignored in `OFF`.
  - If both requests are high, only the one relevant to the current state acts.
- `error_o` behaviour:
  - Cleared by `err_clr_i` or `rst_i`.
  - If `err_clr_i` and a new timeout happen in the same cycle, set wins.
- A wrong-polarity acknowledge in a wait state is ignored.
- `rst_i` asserted mid-sequence returns the block to `ON` reset values on the next edge, regardless of the acknowledge level.

## Timing
- Let `pwr_off_req_i` be sampled high at edge N while in `ON`:
  - `clkgate_en_no` falls at N+1;
  - `iso_no` falls at N+1+G;
  - `rst_no` falls at N+1+2G;
  - `switch_no` rises at N+1+3G (G = `GAP_CYCLES`).
- If `switch_ack_ni`=1 is sampled at edge M, the state is `OFF` at M+1, with `busy_o`=0 and `powered_o`=0.
- Power-up:
  - `switch_no` falls at N+1.
  - If the acknowledge is seen at M, `clkgate_en_no` rises at M+1, `rst_no` at M+1+G, and `iso_no` at M+1+2G.
  - `ON` and `powered_o`=1 are reached at M+1+3G.
- Minimum acknowledge-to-state latency is 1 cycle; an acknowledge already valid on wait-state entry completes on the next edge.
- Timeout: `error_o` rises `ACK_TIMEOUT`+1 cycles after entry to the wait state.

## Structure
- Package `ext_pwr_seq_pkg` holds the 4-bit state enum `pwr_state_e` (`ON`, `PD_CG`, `PD_ISO`, `PD_RST`, `PD_SW`, `OFF`, `PU_SW`, `PU_CG`, `PU_RST`, `PU_ISO`) and the output-decode constants.
- Sub-module `ext_pwr_seq_timer`: a loadable counter with `done_o` (gap elapsed) and `timeout_o` (count == `ACK_TIMEOUT`, suppressed when `ACK_TIMEOUT`=0).

## Test plan
- Reset: hold `rst_i` for 3 cycles → `switch_no`=0, `iso_no`=1, `clkgate_en_no`=1, `rst_no`=0, `error_o`=0; `rst_no`=1 one cycle after release; `powered_o`=1.
- Power-down, G=2, acknowledge model latency 15 cycles: request at edge 10 → `clkgate_en_no`↓@11, `iso_no`↓@13, `rst_no`↓@15, `switch_no`↑@17; acknowledge at ~32 → `OFF` next edge, `error_o`=0.
- Power-up from `OFF`, same acknowledge model: request at edge 10 → `switch_no`↓@11; acknowledge at 26 → `clkgate_en_no`↑@27, `rst_no`↑@29, `iso_no`↑@31, `powered_o`=1@33.
- Timeout: acknowledge withheld, `ACK_TIMEOUT`=64 → `error_o`=1 at 65 cycles after `PD_SW` entry; acknowledge given later → `OFF` reached, `error_o` stays 1 until an `err_clr_i` pulse.
- Ignored requests: `pwr_on_req_i` in `ON`, `pwr_off_req_i` during `PD_ISO`, and `pwr_off_req_i` in `OFF` each cause no state change; both requests high in `OFF` → power-up starts.
- Reset mid-operation: `rst_i` pulse while in `PD_SW` with the acknowledge still 0 → next edge `ON` values (`switch_no`=0, `iso_no`=1, `clkgate_en_no`=1, `rst_no`=0), `busy_o`=0.
